// File: rtl/mc_cu_if.sv
// Control bundle between the multicycle control FSM and its datapath.
// The FSM takes the master side; the datapath or bench takes the slave side.
interface mc_cu_if;
  logic [5:0] op;
  logic [5:0] func;
  logic       z;
  logic       mem_ready;
  logic [2:0] state;
  logic       wpc;
  logic       wir;
  logic       rmem;
  logic       wmem;
  logic       iord;
  logic       wreg;
  logic       regrt;
  logic       m2reg;
  logic       jal;
  logic       sext;
  logic       shift;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [3:0] aluc;
  logic [1:0] pcsource;
  logic       ill_inst;
  logic       bus_err;

  modport master (
    input  op, func, z, mem_ready,
    output state, wpc, wir, rmem, wmem, iord, wreg, regrt, m2reg, jal, sext, shift,
           alusrca, alusrcb, aluc, pcsource, ill_inst, bus_err
  );

  modport slave (
    output op, func, z, mem_ready,
    input  state, wpc, wir, rmem, wmem, iord, wreg, regrt, m2reg, jal, sext, shift,
           alusrca, alusrcb, aluc, pcsource, ill_inst, bus_err
  );
endinterface

// File: rtl/mc_cu_fsm.sv
// Multicycle MIPS-subset control FSM: sequences IF/ID/EXE/MEM/WB over a shared ALU and
// unified memory, with a bounded mem_ready wait that halts on bus error.
module mc_cu_fsm #(
  parameter int unsigned WAIT_LIMIT = 16,
  parameter int unsigned CNT_W      = 5
) (
  input logic     clock,
  input logic     reset,
  mc_cu_if.master bus
);

  typedef enum logic [2:0] {
    StIf   = 3'd0,
    StId   = 3'd1,
    StExe  = 3'd2,
    StMem  = 3'd3,
    StWb   = 3'd4,
    StHalt = 3'd7
  } state_e;

  localparam logic [CNT_W-1:0] LastWait = CNT_W'(WAIT_LIMIT - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             bus_err_q, bus_err_d;

  // Instruction decode
  logic r_type;
  logic i_add, i_sub, i_and, i_or, i_xor, i_sll, i_srl, i_sra, i_jr;
  logic i_addi, i_andi, i_ori, i_xori, i_lw, i_sw, i_beq, i_bne, i_lui, i_j, i_jal;
  logic valid, alu_imm, sext_dec, is_shift;
  logic [3:0] aluc_dec;

  assign r_type = (bus.op == 6'b000000);
  assign i_add  = r_type & (bus.func == 6'b100000);
  assign i_sub  = r_type & (bus.func == 6'b100010);
  assign i_and  = r_type & (bus.func == 6'b100100);
  assign i_or   = r_type & (bus.func == 6'b100101);
  assign i_xor  = r_type & (bus.func == 6'b100110);
  assign i_sll  = r_type & (bus.func == 6'b000000);
  assign i_srl  = r_type & (bus.func == 6'b000010);
  assign i_sra  = r_type & (bus.func == 6'b000011);
  assign i_jr   = r_type & (bus.func == 6'b001000);
  assign i_addi = (bus.op == 6'b001000);
  assign i_andi = (bus.op == 6'b001100);
  assign i_ori  = (bus.op == 6'b001101);
  assign i_xori = (bus.op == 6'b001110);
  assign i_lw   = (bus.op == 6'b100011);
  assign i_sw   = (bus.op == 6'b101011);
  assign i_beq  = (bus.op == 6'b000100);
  assign i_bne  = (bus.op == 6'b000101);
  assign i_lui  = (bus.op == 6'b001111);
  assign i_j    = (bus.op == 6'b000010);
  assign i_jal  = (bus.op == 6'b000011);

  assign valid = i_add | i_sub | i_and | i_or | i_xor | i_sll | i_srl | i_sra | i_jr |
                 i_addi | i_andi | i_ori | i_xori | i_lw | i_sw | i_beq | i_bne | i_lui |
                 i_j | i_jal;
  assign alu_imm  = i_addi | i_andi | i_ori | i_xori | i_lui;
  assign sext_dec = i_addi | i_lw | i_sw | i_beq | i_bne;
  assign is_shift = i_sll | i_srl | i_sra;

  always_comb begin
    aluc_dec = 4'b0000;
    if (i_sub | i_beq | i_bne)  aluc_dec = 4'b0100;
    else if (i_and | i_andi)    aluc_dec = 4'b0001;
    else if (i_or | i_ori)      aluc_dec = 4'b0101;
    else if (i_xor | i_xori)    aluc_dec = 4'b0010;
    else if (i_lui)             aluc_dec = 4'b0110;
    else if (i_sll)             aluc_dec = 4'b0011;
    else if (i_srl)             aluc_dec = 4'b0111;
    else if (i_sra)             aluc_dec = 4'b1111;
  end

  logic       wpc, wir, rmem, wmem, iord, wreg, regrt, m2reg, jal, sext, shift, alusrca;
  logic [1:0] alusrcb, pcsource;
  logic [3:0] aluc;
  logic       ill_inst;
  logic       wait_expired;

  // Completion on the last allowed cycle wins over the timeout.
  assign wait_expired = ~bus.mem_ready & (cnt_q == LastWait);

  always_comb begin
    state_d   = state_q;
    cnt_d     = '0;
    bus_err_d = bus_err_q;
    wpc = 1'b0; wir = 1'b0; rmem = 1'b0; wmem = 1'b0; iord = 1'b0; wreg = 1'b0;
    regrt = 1'b0; m2reg = 1'b0; jal = 1'b0; sext = 1'b0; shift = 1'b0; alusrca = 1'b0;
    alusrcb = 2'b00; aluc = 4'b0000; pcsource = 2'b00; ill_inst = 1'b0;

    case (state_q)
      StIf: begin
        rmem    = 1'b1;
        alusrcb = 2'b01;
        if (bus.mem_ready) begin
          wir     = 1'b1;
          wpc     = 1'b1;
          state_d = StId;
        end else if (wait_expired) begin
          state_d   = StHalt;
          bus_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StId: begin
        alusrcb = 2'b11;
        sext    = 1'b1;
        if (i_j | i_jal) begin
          wpc      = 1'b1;
          pcsource = 2'b11;
          wreg     = i_jal;
          jal      = i_jal;
          state_d  = StIf;
        end else if (i_jr) begin
          wpc      = 1'b1;
          pcsource = 2'b10;
          state_d  = StIf;
        end else if (!valid) begin
          ill_inst = 1'b1;
          state_d  = StIf;
        end else begin
          state_d = StExe;
        end
      end
      StExe: begin
        alusrca = 1'b1;
        shift   = is_shift;
        alusrcb = (alu_imm | i_lw | i_sw) ? 2'b10 : 2'b00;
        aluc    = aluc_dec;
        sext    = sext_dec;
        if (i_beq | i_bne) begin
          if ((i_beq & bus.z) | (i_bne & ~bus.z)) begin
            wpc      = 1'b1;
            pcsource = 2'b01;
          end
          state_d = StIf;
        end else if (i_lw | i_sw) begin
          state_d = StMem;
        end else begin
          state_d = StWb;
        end
      end
      StMem: begin
        iord = 1'b1;
        rmem = i_lw;
        wmem = i_sw;
        if (bus.mem_ready) begin
          state_d = i_lw ? StWb : StIf;
        end else if (wait_expired) begin
          state_d   = StHalt;
          bus_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StWb: begin
        wreg    = 1'b1;
        regrt   = alu_imm | i_lw;
        m2reg   = i_lw;
        state_d = StIf;
      end
      StHalt: ;
      default: state_d = StIf;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= StIf;
      cnt_q     <= '0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bus_err_q <= bus_err_d;
    end
  end

  // Write strobes are suppressed while reset is held so an aborted access leaves no trace.
  assign bus.state    = state_q;
  assign bus.wpc      = wpc  & ~reset;
  assign bus.wir      = wir  & ~reset;
  assign bus.rmem     = rmem & ~reset;
  assign bus.wmem     = wmem & ~reset;
  assign bus.wreg     = wreg & ~reset;
  assign bus.ill_inst = ill_inst & ~reset;
  assign bus.iord     = iord;
  assign bus.regrt    = regrt;
  assign bus.m2reg    = m2reg;
  assign bus.jal      = jal;
  assign bus.sext     = sext;
  assign bus.shift    = shift;
  assign bus.alusrca  = alusrca;
  assign bus.alusrcb  = alusrcb;
  assign bus.aluc     = aluc;
  assign bus.pcsource = pcsource;
  assign bus.bus_err  = bus_err_q;

endmodule

// File: tb/tb_mc_cu_fsm.sv
// Bench for mc_cu_fsm: each scenario queues per-cycle stimulus with hand-derived expected
// outputs, then replays the queue and compares the full output vector every cycle.
module tb_mc_cu_fsm;
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  mc_cu_if bus ();

  mc_cu_fsm #(.WAIT_LIMIT(16), .CNT_W(5)) dut (.clock(clock), .reset(reset), .bus(bus));

  localparam logic [5:0] OpR = 6'b000000, OpAddi = 6'b001000, OpOri = 6'b001101;
  localparam logic [5:0] OpLui = 6'b001111, OpLw = 6'b100011, OpSw = 6'b101011;
  localparam logic [5:0] OpBeq = 6'b000100, OpBne = 6'b000101, OpJ = 6'b000010;
  localparam logic [5:0] OpJal = 6'b000011, OpBad = 6'b111111;
  localparam logic [5:0] FnAdd = 6'b100000, FnSll = 6'b000000, FnSra = 6'b000011;
  localparam logic [5:0] FnJr = 6'b001000, FnBad = 6'b111111;

  typedef struct packed {
    logic [2:0] state;
    logic wpc, wir, rmem, wmem, iord, wreg, regrt, m2reg, jal, sext, shift, alusrca;
    logic [1:0] alusrcb;
    logic [3:0] aluc;
    logic [1:0] pcsource;
    logic ill_inst, bus_err;
  } ov_t;

  typedef struct packed {
    logic rst;
    logic [5:0] op;
    logic [5:0] func;
    logic z;
    logic mr;
    ov_t exp;
  } ent_t;

  ent_t sb[$];
  int checks = 0;
  int failures = 0;

  function automatic ov_t obs();
    ov_t v;
    v.state = bus.state; v.wpc = bus.wpc; v.wir = bus.wir; v.rmem = bus.rmem;
    v.wmem = bus.wmem; v.iord = bus.iord; v.wreg = bus.wreg; v.regrt = bus.regrt;
    v.m2reg = bus.m2reg; v.jal = bus.jal; v.sext = bus.sext; v.shift = bus.shift;
    v.alusrca = bus.alusrca; v.alusrcb = bus.alusrcb; v.aluc = bus.aluc;
    v.pcsource = bus.pcsource; v.ill_inst = bus.ill_inst; v.bus_err = bus.bus_err;
    return v;
  endfunction

  function automatic ov_t st_only(input logic [2:0] s);
    ov_t v = '0;
    v.state = s;
    return v;
  endfunction

  function automatic ov_t if_go();
    ov_t v = st_only(3'd0);
    v.wpc = 1'b1; v.wir = 1'b1; v.rmem = 1'b1; v.alusrcb = 2'b01;
    return v;
  endfunction

  function automatic ov_t if_wait();
    ov_t v = st_only(3'd0);
    v.rmem = 1'b1; v.alusrcb = 2'b01;
    return v;
  endfunction

  function automatic ov_t if_in_reset();
    ov_t v = st_only(3'd0);
    v.alusrcb = 2'b01;
    return v;
  endfunction

  function automatic ov_t id_base();
    ov_t v = st_only(3'd1);
    v.sext = 1'b1; v.alusrcb = 2'b11;
    return v;
  endfunction

  function automatic ov_t exe(input logic [1:0] srcb, input logic [3:0] aluc,
                              input logic sext, input logic shift);
    ov_t v = st_only(3'd2);
    v.alusrca = 1'b1; v.alusrcb = srcb; v.aluc = aluc; v.sext = sext; v.shift = shift;
    return v;
  endfunction

  function automatic ov_t wb(input logic regrt, input logic m2reg);
    ov_t v = st_only(3'd4);
    v.wreg = 1'b1; v.regrt = regrt; v.m2reg = m2reg;
    return v;
  endfunction

  task automatic push(input logic rst, input logic [5:0] op, input logic [5:0] func,
                      input logic z, input logic mr, input ov_t e);
    ent_t n;
    n.rst = rst; n.op = op; n.func = func; n.z = z; n.mr = mr; n.exp = e;
    sb.push_back(n);
  endtask

  // Full fetch/decode/execute/writeback of a register-writing ALU instruction.
  task automatic push_alu(input logic [5:0] op, input logic [5:0] func, input ov_t e_exe,
                          input logic regrt);
    push(1'b0, op, func, 1'b0, 1'b1, if_go());
    push(1'b0, op, func, 1'b0, 1'b1, id_base());
    push(1'b0, op, func, 1'b0, 1'b1, e_exe);
    push(1'b0, op, func, 1'b0, 1'b1, wb(regrt, 1'b0));
  endtask

  task automatic test_reset();
    int step = 0;
    reset = 1'b1; bus.op = '0; bus.func = '0; bus.z = 1'b0; bus.mem_ready = 1'b0;
    repeat (2) @(negedge clock);
    push(1'b1, OpR, FnAdd, 1'b0, 1'b1, if_in_reset());
    push(1'b1, OpR, FnAdd, 1'b0, 1'b0, if_in_reset());
    push(1'b0, OpR, FnAdd, 1'b0, 1'b0, if_wait());
    while (sb.size() != 0) begin
      ent_t n; ov_t got;
      n = sb.pop_front();
      @(negedge clock);
      reset = n.rst; bus.op = n.op; bus.func = n.func; bus.z = n.z; bus.mem_ready = n.mr;
      #1; got = obs(); checks++; step++;
      if (got !== n.exp) begin
        failures++;
        $display("FAIL reset step %0d: got %h want %h", step, got, n.exp);
      end
    end
  endtask

  task automatic test_add_lw();
    int step = 0;
    push_alu(OpR, FnAdd, exe(2'b00, 4'b0000, 1'b0, 1'b0), 1'b0);
    push(1'b0, OpLw, 6'd0, 1'b0, 1'b1, if_go());
    push(1'b0, OpLw, 6'd0, 1'b0, 1'b1, id_base());
    push(1'b0, OpLw, 6'd0, 1'b0, 1'b1, exe(2'b10, 4'b0000, 1'b1, 1'b0));
    begin
      ov_t m = st_only(3'd3);
      m.iord = 1'b1; m.rmem = 1'b1;
      push(1'b0, OpLw, 6'd0, 1'b0, 1'b1, m);
    end
    push(1'b0, OpLw, 6'd0, 1'b0, 1'b1, wb(1'b1, 1'b1));
    push(1'b0, OpLw, 6'd0, 1'b0, 1'b0, if_wait());
    while (sb.size() != 0) begin
      ent_t n; ov_t got;
      n = sb.pop_front();
      @(negedge clock);
      reset = n.rst; bus.op = n.op; bus.func = n.func; bus.z = n.z; bus.mem_ready = n.mr;
      #1; got = obs(); checks++; step++;
      if (got !== n.exp) begin
        failures++;
        $display("FAIL add_lw step %0d: got %h want %h", step, got, n.exp);
      end
    end
  endtask

  task automatic test_alu_ops();
    int step = 0;
    push_alu(OpR, FnSll, exe(2'b00, 4'b0011, 1'b0, 1'b1), 1'b0);
    push_alu(OpR, FnSra, exe(2'b00, 4'b1111, 1'b0, 1'b1), 1'b0);
    push_alu(OpOri, 6'd0, exe(2'b10, 4'b0101, 1'b0, 1'b0), 1'b1);
    push_alu(OpAddi, 6'd0, exe(2'b10, 4'b0000, 1'b1, 1'b0), 1'b1);
    push_alu(OpLui, 6'd0, exe(2'b10, 4'b0110, 1'b0, 1'b0), 1'b1);
    push(1'b0, OpR, FnAdd, 1'b0, 1'b0, if_wait());
    while (sb.size() != 0) begin
      ent_t n; ov_t got;
      n = sb.pop_front();
      @(negedge clock);
      reset = n.rst; bus.op = n.op; bus.func = n.func; bus.z = n.z; bus.mem_ready = n.mr;
      #1; got = obs(); checks++; step++;
      if (got !== n.exp) begin
        failures++;
        $display("FAIL alu_ops step %0d: got %h want %h", step, got, n.exp);
      end
    end
  endtask

  task automatic test_branch();
    int step = 0;
    ov_t taken_beq = exe(2'b00, 4'b0100, 1'b1, 1'b0);
    ov_t not_taken = exe(2'b00, 4'b0100, 1'b1, 1'b0);
    taken_beq.wpc = 1'b1; taken_beq.pcsource = 2'b01;
    // beq z=1 taken; bne z=1 not taken (z high in ID too, must be ignored); bne z=0 taken
    push(1'b0, OpBeq, 6'd0, 1'b0, 1'b1, if_go());
    push(1'b0, OpBeq, 6'd0, 1'b1, 1'b1, id_base());
    push(1'b0, OpBeq, 6'd0, 1'b1, 1'b1, taken_beq);
    push(1'b0, OpBne, 6'd0, 1'b1, 1'b1, if_go());
    push(1'b0, OpBne, 6'd0, 1'b1, 1'b1, id_base());
    push(1'b0, OpBne, 6'd0, 1'b1, 1'b1, not_taken);
    push(1'b0, OpBne, 6'd0, 1'b0, 1'b1, if_go());
    push(1'b0, OpBne, 6'd0, 1'b0, 1'b1, id_base());
    push(1'b0, OpBne, 6'd0, 1'b0, 1'b1, taken_beq);
    push(1'b0, OpBne, 6'd0, 1'b0, 1'b0, if_wait());
    while (sb.size() != 0) begin
      ent_t n; ov_t got;
      n = sb.pop_front();
      @(negedge clock);
      reset = n.rst; bus.op = n.op; bus.func = n.func; bus.z = n.z; bus.mem_ready = n.mr;
      #1; got = obs(); checks++; step++;
      if (got !== n.exp) begin
        failures++;
        $display("FAIL branch step %0d: got %h want %h", step, got, n.exp);
      end
    end
  endtask

  task automatic test_sw_wait();
    int step = 0;
    ov_t m = st_only(3'd3);
    m.iord = 1'b1; m.wmem = 1'b1;
    push(1'b0, OpSw, 6'd0, 1'b0, 1'b1, if_go());
    push(1'b0, OpSw, 6'd0, 1'b0, 1'b0, id_base());
    push(1'b0, OpSw, 6'd0, 1'b0, 1'b1, exe(2'b10, 4'b0000, 1'b1, 1'b0));
    for (int i = 0; i < 3; i++) push(1'b0, OpSw, 6'd0, 1'b0, 1'b0, m);
    push(1'b0, OpSw, 6'd0, 1'b0, 1'b1, m);
    push(1'b0, OpSw, 6'd0, 1'b0, 1'b0, if_wait());
    while (sb.size() != 0) begin
      ent_t n; ov_t got;
      n = sb.pop_front();
      @(negedge clock);
      reset = n.rst; bus.op = n.op; bus.func = n.func; bus.z = n.z; bus.mem_ready = n.mr;
      #1; got = obs(); checks++; step++;
      if (got !== n.exp) begin
        failures++;
        $display("FAIL sw_wait step %0d: got %h want %h", step, got, n.exp);
      end
    end
  endtask

  task automatic test_bus_timeout();
    int step = 0;
    ov_t h = st_only(3'd7);
    h.bus_err = 1'b1;
    push(1'b1, OpR, FnAdd, 1'b0, 1'b0, if_in_reset());
    for (int i = 0; i < 16; i++) push(1'b0, OpR, FnAdd, 1'b0, 1'b0, if_wait());
    for (int i = 0; i < 3; i++) push(1'b0, OpR, FnAdd, 1'b1, 1'b1, h);
    push(1'b1, OpR, FnAdd, 1'b0, 1'b1, h);
    // Variant: mem_ready arrives on the 16th and last allowed cycle.
    for (int i = 0; i < 15; i++) push(1'b0, OpR, FnAdd, 1'b0, 1'b0, if_wait());
    push(1'b0, OpR, FnAdd, 1'b0, 1'b1, if_go());
    push(1'b0, OpR, FnAdd, 1'b0, 1'b1, id_base());
    push(1'b0, OpR, FnAdd, 1'b0, 1'b1, exe(2'b00, 4'b0000, 1'b0, 1'b0));
    push(1'b0, OpR, FnAdd, 1'b0, 1'b1, wb(1'b0, 1'b0));
    push(1'b0, OpR, FnAdd, 1'b0, 1'b0, if_wait());
    while (sb.size() != 0) begin
      ent_t n; ov_t got;
      n = sb.pop_front();
      @(negedge clock);
      reset = n.rst; bus.op = n.op; bus.func = n.func; bus.z = n.z; bus.mem_ready = n.mr;
      #1; got = obs(); checks++; step++;
      if (got !== n.exp) begin
        failures++;
        $display("FAIL bus_timeout step %0d: got %h want %h", step, got, n.exp);
      end
    end
  endtask

  task automatic test_illegal();
    int step = 0;
    ov_t bad = id_base();
    bad.ill_inst = 1'b1;
    push(1'b0, OpBad, 6'd0, 1'b0, 1'b1, if_go());
    push(1'b0, OpBad, 6'd0, 1'b0, 1'b1, bad);
    push(1'b0, OpR, FnBad, 1'b0, 1'b1, if_go());
    push(1'b0, OpR, FnBad, 1'b0, 1'b1, bad);
    push(1'b0, OpR, FnBad, 1'b0, 1'b0, if_wait());
    while (sb.size() != 0) begin
      ent_t n; ov_t got;
      n = sb.pop_front();
      @(negedge clock);
      reset = n.rst; bus.op = n.op; bus.func = n.func; bus.z = n.z; bus.mem_ready = n.mr;
      #1; got = obs(); checks++; step++;
      if (got !== n.exp) begin
        failures++;
        $display("FAIL illegal step %0d: got %h want %h", step, got, n.exp);
      end
    end
  endtask

  task automatic test_reset_mid_op_and_jumps();
    int step = 0;
    ov_t m = st_only(3'd3);
    ov_t m_rst = st_only(3'd3);
    ov_t jal_id = id_base();
    ov_t j_id = id_base();
    ov_t jr_id = id_base();
    m.iord = 1'b1; m.rmem = 1'b1;
    m_rst.iord = 1'b1;
    jal_id.wpc = 1'b1; jal_id.wreg = 1'b1; jal_id.jal = 1'b1; jal_id.pcsource = 2'b11;
    j_id.wpc = 1'b1; j_id.pcsource = 2'b11;
    jr_id.wpc = 1'b1; jr_id.pcsource = 2'b10;
    push(1'b0, OpLw, 6'd0, 1'b0, 1'b1, if_go());
    push(1'b0, OpLw, 6'd0, 1'b0, 1'b1, id_base());
    push(1'b0, OpLw, 6'd0, 1'b0, 1'b1, exe(2'b10, 4'b0000, 1'b1, 1'b0));
    push(1'b0, OpLw, 6'd0, 1'b0, 1'b0, m);
    push(1'b1, OpLw, 6'd0, 1'b0, 1'b1, m_rst);
    push(1'b0, OpLw, 6'd0, 1'b0, 1'b0, if_wait());
    push(1'b0, OpJal, 6'd0, 1'b0, 1'b1, if_go());
    push(1'b0, OpJal, 6'd0, 1'b0, 1'b1, jal_id);
    push(1'b0, OpJ, 6'd0, 1'b0, 1'b1, if_go());
    push(1'b0, OpJ, 6'd0, 1'b0, 1'b1, j_id);
    push(1'b0, OpR, FnJr, 1'b0, 1'b1, if_go());
    push(1'b0, OpR, FnJr, 1'b0, 1'b1, jr_id);
    push(1'b0, OpR, FnJr, 1'b0, 1'b0, if_wait());
    while (sb.size() != 0) begin
      ent_t n; ov_t got;
      n = sb.pop_front();
      @(negedge clock);
      reset = n.rst; bus.op = n.op; bus.func = n.func; bus.z = n.z; bus.mem_ready = n.mr;
      #1; got = obs(); checks++; step++;
      if (got !== n.exp) begin
        failures++;
        $display("FAIL reset_mid_op step %0d: got %h want %h", step, got, n.exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_add_lw();
    test_alu_ops();
    test_branch();
    test_sw_wait();
    test_bus_timeout();
    test_illegal();
    test_reset_mid_op_and_jumps();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
